// File: rtl/as_jtag_imem_host_pkg.sv
// Shared definitions for the JTAG I-Mem boot-load host.
// Scan geometry, IR opcode and host FSM states.
package as_jtag_imem_host_pkg;

   localparam int ir_width       = 8;
   localparam int im_addr_width  = 15;
   localparam int im_data_width  = 32;
   localparam int im_scan_length = im_addr_width + im_data_width + 1;

   localparam logic [ir_width-1:0] jtag_imem_opc_c = 8'h02;
   localparam int jtag_tlr_steps_c = 5;

   typedef enum logic [3:0] {
      JH_TLR,
      JH_IDLE,
      JH_IR_HDR,
      JH_IR_SHIFT,
      JH_IR_TAIL,
      JH_DR_HDR,
      JH_DR_SHIFT,
      JH_DR_TAIL,
      JH_DONE
   } e_jtag_host_st;

   // TMS for a tck step, given the steps still left in that state
   function automatic logic jtag_host_tms(e_jtag_host_st st,
                                          int unsigned cnt);
      logic t;
      case (st)
         JH_TLR:                   t = (cnt != 0);
         JH_IR_HDR:                t = (cnt >= 2);
         JH_IR_SHIFT, JH_DR_SHIFT: t = (cnt == 0);
         JH_IR_TAIL, JH_DR_TAIL:   t = (cnt == 1);
         JH_DR_HDR:                t = (cnt == 2);
         default:                  t = 1'b0;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/as_jtag_imem_host_tck.sv
// TCK divider: toggles tck every TCK_HALF clks while run is high.
// fall_en / rise_en flag the clk cycle in which tck changes.
module as_jtag_tck_gen #(
   parameter int TCK_HALF = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic tck,
   output logic fall_en,
   output logic rise_en
);

   localparam int DIV_W = (TCK_HALF > 1) ? $clog2(TCK_HALF) : 1;
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TCK_HALF - 1);

   logic [DIV_W-1:0] div_q, div_d;
   logic             tck_q, tck_d;
   logic             wrap;

   always_comb begin
      wrap  = run && (div_q == DIV_MAX);
      div_d = div_q;
      tck_d = tck_q;
      if (!run) begin
         div_d = '0;
         tck_d = 1'b0;
      end else if (wrap) begin
         div_d = '0;
         tck_d = ~tck_q;
      end else begin
         div_d = div_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q <= '0;
         tck_q <= 1'b0;
      end else begin
         div_q <= div_d;
         tck_q <= tck_d;
      end
   end

   assign tck     = tck_q;
   assign fall_en = wrap && tck_q;
   assign rise_en = wrap && !tck_q;

endmodule

// File: rtl/as_jtag_imem_host.sv
// JTAG TAP initiator that loads the core I-Mem through its scan DR.
// One request = optional IR load, then one full DR scan.
module as_jtag_imem_host
   import as_jtag_imem_host_pkg::*;
#(
   parameter int TCK_HALF = 4,
   parameter int IR_W = ir_width,
   parameter logic [IR_W-1:0] IMEM_OPC = IR_W'(jtag_imem_opc_c),
   parameter int AW = im_addr_width,
   parameter int DW = im_data_width,
   parameter int SCAN_W = AW + DW + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [AW-1:0]     req_addr,
   input  logic [DW-1:0]     req_data,
   input  logic              req_wen,
   input  logic              reinit,
   output logic              done,
   output logic [SCAN_W-1:0] rd_vec,
   output logic              tck,
   output logic              tms,
   output logic              tdi,
   input  logic              tdo
);

   localparam int CW = $clog2(SCAN_W + 1);

   e_jtag_host_st     state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d, cnt_dec;
   logic              tms_q, tms_d;
   logic              tdi_q, tdi_d;
   logic [SCAN_W-1:0] vec_q, vec_d;
   logic [IR_W-1:0]   irsh_q, irsh_d;
   logic [SCAN_W-1:0] cap_q, cap_d;
   logic [SCAN_W-1:0] rd_vec_q, rd_vec_d;
   logic              ir_loaded_q, ir_loaded_d;
   logic              reinit_pend_q, reinit_pend_d;
   logic              run, fall_en, rise_en, last;

   // Steps remaining after the first step of a freshly entered state
   function automatic logic [CW-1:0] entry_cnt(e_jtag_host_st s);
      logic [CW-1:0] c;
      case (s)
         JH_TLR:      c = CW'(jtag_tlr_steps_c);
         JH_IR_HDR:   c = CW'(3);
         JH_IR_SHIFT: c = CW'(IR_W - 1);
         JH_IR_TAIL:  c = CW'(1);
         JH_DR_HDR:   c = CW'(2);
         JH_DR_SHIFT: c = CW'(SCAN_W - 1);
         JH_DR_TAIL:  c = CW'(1);
         default:     c = '0;
      endcase
      return c;
   endfunction

   as_jtag_tck_gen #(
      .TCK_HALF (TCK_HALF)
   ) u_tck (
      .clk     (clk),
      .rst     (rst),
      .run     (run),
      .tck     (tck),
      .fall_en (fall_en),
      .rise_en (rise_en)
   );

   assign last    = fall_en && (cnt_q == '0);
   assign cnt_dec = cnt_q - 1'b1;

   always_ff @(posedge clk) begin
      if (rst) state_q <= JH_TLR;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         JH_TLR:      if (last) state_d = JH_IDLE;
         JH_IDLE: begin
            if (reinit)         state_d = JH_TLR;
            else if (req_valid) state_d = ir_loaded_q ? JH_DR_HDR
                                                      : JH_IR_HDR;
         end
         JH_IR_HDR:   if (last) state_d = JH_IR_SHIFT;
         JH_IR_SHIFT: if (last) state_d = JH_IR_TAIL;
         JH_IR_TAIL:  if (last) state_d = JH_DR_HDR;
         JH_DR_HDR:   if (last) state_d = JH_DR_SHIFT;
         JH_DR_SHIFT: if (last) state_d = JH_DR_TAIL;
         JH_DR_TAIL:  if (last) state_d = JH_DONE;
         JH_DONE: begin
            state_d = (reinit_pend_q || reinit) ? JH_TLR : JH_IDLE;
         end
         default:     state_d = JH_TLR;
      endcase
   end

   // A reinit in IDLE blocks acceptance so the TLR is never skipped
   always_comb begin
      req_ready = (state_q == JH_IDLE) && !reinit;
      done      = (state_q == JH_DONE);
      run       = !(state_q inside {JH_IDLE, JH_DONE});
   end

   always_comb begin
      cnt_d         = cnt_q;
      tms_d         = tms_q;
      tdi_d         = tdi_q;
      vec_d         = vec_q;
      irsh_d        = irsh_q;
      cap_d         = cap_q;
      rd_vec_d      = rd_vec_q;
      ir_loaded_d   = ir_loaded_q;
      reinit_pend_d = reinit_pend_q;

      if (req_valid && req_ready) vec_d = {req_wen, req_data, req_addr};

      if (state_d != state_q) begin
         cnt_d = entry_cnt(state_d);
         tms_d = jtag_host_tms(state_d, 32'(entry_cnt(state_d)));
         tdi_d = 1'b0;
         if (state_d == JH_IR_SHIFT) begin
            irsh_d = IMEM_OPC;
            tdi_d  = IMEM_OPC[0];
         end
         if (state_d == JH_DR_SHIFT) tdi_d = vec_q[0];
         if (state_d == JH_DONE) rd_vec_d = cap_q;
      end else if (fall_en) begin
         cnt_d = cnt_dec;
         tms_d = jtag_host_tms(state_q, 32'(cnt_dec));
         if (state_q == JH_IR_SHIFT) begin
            tdi_d  = irsh_q[1];
            irsh_d = {1'b0, irsh_q[IR_W-1:1]};
         end
         if (state_q == JH_DR_SHIFT) begin
            tdi_d = vec_q[1];
            vec_d = {1'b0, vec_q[SCAN_W-1:1]};
         end
      end

      if (rise_en && state_q == JH_DR_SHIFT) begin
         cap_d = {tdo, cap_q[SCAN_W-1:1]};
      end

      if (state_q == JH_IR_TAIL && state_d == JH_DR_HDR) begin
         ir_loaded_d = 1'b1;
      end
      if (reinit && !(state_q inside {JH_IDLE, JH_TLR})) begin
         reinit_pend_d = 1'b1;
      end
      if (state_d == JH_TLR) begin
         ir_loaded_d   = 1'b0;
         reinit_pend_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q         <= CW'(jtag_tlr_steps_c);
         tms_q         <= 1'b1;
         tdi_q         <= 1'b0;
         vec_q         <= '0;
         irsh_q        <= '0;
         cap_q         <= '0;
         rd_vec_q      <= '0;
         ir_loaded_q   <= 1'b0;
         reinit_pend_q <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         tms_q         <= tms_d;
         tdi_q         <= tdi_d;
         vec_q         <= vec_d;
         irsh_q        <= irsh_d;
         cap_q         <= cap_d;
         rd_vec_q      <= rd_vec_d;
         ir_loaded_q   <= ir_loaded_d;
         reinit_pend_q <= reinit_pend_d;
      end
   end

   assign tms    = tms_q;
   assign tdi    = tdi_q;
   assign rd_vec = rd_vec_q;

endmodule

// File: tb/tb_as_jtag_imem_host.sv
// Bench for as_jtag_imem_host with a behavioural target TAP model.
// Expected scan results are queued at request time and popped on done.
module tb_as_jtag_imem_host;

   localparam int AW = 15;
   localparam int DW = 32;
   localparam int SW = 48;

   typedef enum logic [3:0] {
      T_TLR, T_RTI, T_SELDR, T_CAPDR, T_SHDR, T_EX1DR, T_PSDR, T_EX2DR,
      T_UPDR, T_SELIR, T_CAPIR, T_SHIR, T_EX1IR, T_PSIR, T_EX2IR, T_UPIR
   } tap_t;

   typedef struct {
      logic [SW-1:0] rd;
      int            steps;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          wen;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_wen = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_data = '0;
   logic          reinit = 1'b0;
   logic          tdo = 1'b0;
   logic          req_ready, done, tck, tms, tdi;
   logic [SW-1:0] rd_vec;

   as_jtag_imem_host #(
      .TCK_HALF (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .req_wen   (req_wen),
      .reinit    (reinit),
      .done      (done),
      .rd_vec    (rd_vec),
      .tck       (tck),
      .tms       (tms),
      .tdi       (tdi),
      .tdo       (tdo)
   );

   always #5 clk = ~clk;

   // Target TAP model
   tap_t          tap = T_TLR;
   logic [7:0]    m_ir = 8'hFF;
   logic [7:0]    m_irsh = '0;
   logic [SW-1:0] m_drsh = '0;
   logic [SW-1:0] m_cap_val = '0;
   logic [SW-1:0] m_last_upd = '0;
   logic [DW-1:0] mem [0:63];
   int            m_writes = 0;
   int            m_tlr_cnt = 0;
   int            rises = 0;
   logic [63:0]   tms_hist = '0;

   function automatic tap_t next_tap(tap_t s, logic m);
      case (s)
         T_TLR:   return m ? T_TLR   : T_RTI;
         T_RTI:   return m ? T_SELDR : T_RTI;
         T_SELDR: return m ? T_SELIR : T_CAPDR;
         T_CAPDR: return m ? T_EX1DR : T_SHDR;
         T_SHDR:  return m ? T_EX1DR : T_SHDR;
         T_EX1DR: return m ? T_UPDR  : T_PSDR;
         T_PSDR:  return m ? T_EX2DR : T_PSDR;
         T_EX2DR: return m ? T_UPDR  : T_SHDR;
         T_UPDR:  return m ? T_SELDR : T_RTI;
         T_SELIR: return m ? T_TLR   : T_CAPIR;
         T_CAPIR: return m ? T_EX1IR : T_SHIR;
         T_SHIR:  return m ? T_EX1IR : T_SHIR;
         T_EX1IR: return m ? T_UPIR  : T_PSIR;
         T_PSIR:  return m ? T_EX2IR : T_PSIR;
         T_EX2IR: return m ? T_UPIR  : T_SHIR;
         default: return m ? T_SELDR : T_RTI;
      endcase
   endfunction

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = '0;
   end

   always @(posedge tck) begin
      rises    <= rises + 1;
      tms_hist <= {tms_hist[62:0], tms};
      tap      <= next_tap(tap, tms);
      if (tap != T_TLR && next_tap(tap, tms) == T_TLR)
         m_tlr_cnt <= m_tlr_cnt + 1;
      case (tap)
         T_TLR:   m_ir   <= 8'hFF;
         T_CAPIR: m_irsh <= 8'h01;
         T_SHIR:  m_irsh <= {tdi, m_irsh[7:1]};
         T_UPIR:  m_ir   <= m_irsh;
         T_CAPDR: m_drsh <= m_cap_val;
         T_SHDR:  m_drsh <= {tdi, m_drsh[SW-1:1]};
         T_UPDR: begin
            m_last_upd <= m_drsh;
            if (m_ir == 8'h02 && m_drsh[SW-1]) begin
               mem[m_drsh[5:0]] <= m_drsh[SW-2:AW];
               m_writes <= m_writes + 1;
            end
         end
         default: ;
      endcase
   end

   always @(negedge tck) begin
      tdo <= (tap == T_SHDR) ? m_drsh[0] :
             (tap == T_SHIR) ? m_irsh[0] : 1'b0;
   end

   int   checks = 0;
   int   failures = 0;
   int   rises0 = 0;
   int   n, r0, tl0, w0;
   exp_t exp_q[$];

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_req(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic w, input logic [SW-1:0] pat,
                           input int steps, input bit push);
      int k = 0;
      m_cap_val = pat;
      @(negedge clk);
      while (!req_ready && k < 2000) begin
         @(negedge clk);
         k++;
      end
      chk("req_ready_high", 64'(req_ready), 64'd1);
      req_valid = 1'b1;
      req_addr  = a;
      req_data  = d;
      req_wen   = w;
      @(posedge clk);
      #1;
      rises0 = rises;
      if (push) exp_q.push_back('{pat, steps, a, d, w});
      chk("req_ready_drop", 64'(req_ready), 64'd0);
      req_valid = 1'b0;
      req_addr  = ~a;
      req_data  = ~d;
      req_wen   = ~w;
   endtask

   task automatic wait_done_check();
      int   k = 0;
      exp_t e;
      while (done !== 1'b1 && k < 3000) begin
         @(negedge clk);
         k++;
      end
      chk("done_seen", 64'(done), 64'd1);
      if (done === 1'b1 && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("rd_vec", 64'(rd_vec), 64'(e.rd));
         chk("tck_steps", 64'(rises - rises0), 64'(e.steps));
         chk("dr_update", 64'(m_last_upd), 64'({e.wen, e.data, e.addr}));
         chk("ir_opcode", 64'(m_ir), 64'h02);
         if (e.wen) chk("mem_write", 64'(mem[e.addr[5:0]]), 64'(e.data));
         @(negedge clk);
         chk("done_one_clk", 64'(done), 64'd0);
      end
   endtask

   task automatic wait_ready(input int limit);
      int k = 0;
      while (!req_ready && k < limit) begin
         @(posedge clk);
         #1;
         k++;
      end
      n = k;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tck", 64'(tck), 64'd0);
      chk("rst_tms", 64'(tms), 64'd1);
      chk("rst_tdi", 64'(tdi), 64'd0);
      chk("rst_ready", 64'(req_ready), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_rd_vec", 64'(rd_vec), 64'd0);

      @(negedge clk);
      rst = 1'b0;
      r0 = rises;
      wait_ready(200);
      chk("tlr_clks", 64'(n), 64'd48);
      chk("tlr_steps", 64'(rises - r0), 64'd6);
      chk("tlr_tms_seq", 64'(tms_hist[5:0]), 64'b111110);
      chk("tap_rti", 64'(tap), 64'(T_RTI));

      send_req(15'h0004, 32'h00500093, 1'b1, 48'hA5A5_1234_5678, 67, 1'b1);
      wait_done_check();

      send_req(15'h0005, 32'h00A00113, 1'b1, 48'h0F0F_F0F0_3C3C, 53, 1'b1);
      wait_done_check();

      w0 = m_writes;
      send_req(15'h0004, 32'hFFFF_FFFF, 1'b0, 48'h8000_0000_0001, 53, 1'b1);
      wait_done_check();
      chk("read_no_write", 64'(m_writes - w0), 64'd0);
      chk("read_mem_kept", 64'(mem[4]), 64'h00500093);

      send_req(15'h0006, 32'h1234_5678, 1'b1, 48'h5555_AAAA_0001, 53, 1'b1);
      n = 0;
      while (rises - rises0 < 20 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      reinit = 1'b1;
      @(negedge clk);
      reinit = 1'b0;
      wait_done_check();
      r0  = rises;
      tl0 = m_tlr_cnt;
      wait_ready(400);
      chk("reinit_tlr_steps", 64'(rises - r0), 64'd6);
      chk("reinit_tap_tlr", 64'(m_tlr_cnt - tl0), 64'd1);
      chk("reinit_tap_rti", 64'(tap), 64'(T_RTI));
      send_req(15'h0007, 32'hCAFE_BABE, 1'b1, 48'h1357_9BDF_2468, 67, 1'b1);
      wait_done_check();

      send_req(15'h0008, 32'hDEAD_0000, 1'b1, 48'h0, 53, 1'b0);
      n = 0;
      while (rises - rises0 < 24 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      rst = 1'b1;
      w0  = m_writes;
      tl0 = m_tlr_cnt;
      @(posedge clk);
      #1;
      chk("midrst_tms", 64'(tms), 64'd1);
      chk("midrst_tck", 64'(tck), 64'd0);
      chk("midrst_done", 64'(done), 64'd0);
      chk("midrst_rd_vec", 64'(rd_vec), 64'd0);
      chk("midrst_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      r0 = rises;
      wait_ready(200);
      chk("midrst_tlr_clks", 64'(n), 64'd48);
      chk("midrst_tlr_steps", 64'(rises - r0), 64'd6);
      chk("midrst_tap_tlr", 64'(m_tlr_cnt - tl0), 64'd1);
      chk("midrst_tap_rti", 64'(tap), 64'(T_RTI));
      chk("midrst_no_write", 64'(m_writes - w0), 64'd0);
      chk("midrst_mem8", 64'(mem[8]), 64'd0);

      send_req(15'h0009, 32'h0000_0013, 1'b1, 48'hFEDC_BA98_7654, 67, 1'b1);
      wait_done_check();
      chk("queue_empty", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/as_jtag_imem_host.md
Name: as_jtag_imem_host

Overview:
- JTAG host (TAP initiator) that drives the chip's TAP controller to load the instruction memory through the I-Mem scan data register.
- Accepts {addr, data, w_en} requests over a valid/ready handshake and generates TCK/TMS/TDI.
- Captures TDO into a readback word.
- Used on the FPGA/bench side to boot-load programs into the core's I-Mem; the far end of the TAP's I-Mem DR.

Parameters:
- TCK_HALF, 4, clk cycles per TCK half-period (TCK = clk/(2*TCK_HALF)); legal values ≥ 1.
- IR_W, ir_width (8), instruction register length.
- IMEM_OPC, 8'h02, IR opcode that selects the I-Mem scan DR.
- AW, im_addr_width (15), address bits in the scan vector.
- DW, im_data_width (32), data bits in the scan vector.
- SCAN_W, im_scan_length (48), DR length = AW+DW+1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  host idle and able to accept
- req_addr  in  AW  I-Mem word address
- req_data  in  DW  instruction word
- req_wen  in  1  1 = write, 0 = read-only scan
- reinit  in  1  1-cycle pulse: force Test-Logic-Reset and IR reload before the next request
- done  out  1  1-cycle pulse: DR scan finished
- rd_vec  out  SCAN_W  TDO bits captured during the last DR scan
- tck  out  1  JTAG clock
- tms  out  1  JTAG mode select
- tdi  out  1  JTAG data to target
- tdo  in  1  JTAG data from target

Behaviour:
- Reset values: tck=0, tms=1, tdi=0, req_ready=0, done=0, rd_vec=0, ir_loaded=0, FSM=TLR.
- TCK generation: a divider counter toggles tck every TCK_HALF clks.
  - tms/tdi update in the clk cycle where tck falls.
  - tdo is sampled in the clk cycle where tck rises.
  - One TCK period = one "tck step".
- FSM states: TLR, IDLE, IR_HDR, IR_SHIFT, IR_TAIL, DR_HDR, DR_SHIFT, DR_TAIL, DONE.
- TLR: 5 steps tms=1, then 1 step tms=0, ending in target Run-Test/Idle → IDLE. 6 steps total.
- IDLE:
  - tck held 0, tms=0, req_ready=1.
  - On req_valid&&req_ready, latch the vector vec = {req_wen, req_data, req_addr}; bit 0 = addr[0], shifted first.
  - Go to IR_HDR if !ir_loaded, else DR_HDR.
  - req_ready drops the cycle after acceptance.
- IR_HDR: tms sequence 1,1,0,0 (Select-DR, Select-IR, Capture-IR, Shift-IR).
- IR_SHIFT: IR_W steps; tdi=IMEM_OPC LSB first; tms=0 except tms=1 on the last bit (Exit1-IR).
- IR_TAIL: tms 1,0 (Update-IR, RTI); set ir_loaded=1 → DR_HDR. IR scan totals 14 steps.
- DR_HDR: tms 1,0,0 (Select-DR, Capture-DR, Shift-DR).
- DR_SHIFT:
  - SCAN_W steps, vec LSB first, tms=1 on the last bit.
  - Each rising tck shifts tdo into the capture shift register MSB-side, so after SCAN_W bits capture[0] = first TDO bit.
- DR_TAIL: tms 1,0 (Update-DR, RTI). DR scan totals 53 steps.
- DONE: rd_vec <= capture, done=1 for exactly one clk → IDLE.
- Counters:
  - Bit counter width is ceil(log2(SCAN_W+1)); it counts down to 0 with no wrap.
  - Divider counter wraps at TCK_HALF-1.
- reinit:
  - In IDLE: go to TLR and clear ir_loaded.
  - In any other state: a sticky flag is set and honoured on return to IDLE; the in-flight request completes first.
- req_valid is ignored while req_ready=0; request inputs need not stay stable after acceptance.
- rst mid-scan: all state returns to reset values on the next clk; the FSM restarts at TLR, so the target TAP is re-synchronised.
- tck never glitches: every state transition occurs at a tck falling edge.

Decomposition:
- Add to the shared package:
  - enum e_jtag_host_st (9 states).
  - localparam jtag_imem_opc_c = 8'h02.
  - localparam jtag_tlr_steps_c = 5.
  - Reuse im_scan_length and ir_width.
- One sub-module, as_jtag_tck_gen: the divider.
  - Outputs tck, fall_en and rise_en strobes.
  - Inputs run (tck held 0 when low) and rst.

Test Plan:
- Reset, then release:
  - 6 tck periods with tms=1,1,1,1,1,0.
  - req_ready rises after the 6th falling edge.
  - With TCK_HALF=4, that is 48 clks after rst deasserts.
- First write, addr=15'h0004, data=32'h00500093, wen=1, with a TAP model attached:
  - IR captures 8'h02.
  - DR update delivers {1, 32'h00500093, 15'h0004}.
  - done pulses once after 14+53 tck steps.
  - Model memory[4]=32'h00500093.
- Second write (addr 5): no IR scan (53 steps only); memory[5] is written.
- TAP model returns the pattern 48'hA5A5_1234_5678 on TDO during the DR scan → rd_vec=48'hA5A5_1234_5678.
- reinit pulsed mid-DR-scan:
  - The current scan completes and done pulses.
  - The host then does TLR (6 steps), then the next request includes an IR scan.
- rst asserted at DR_SHIFT bit 20:
  - Next clk: tms=1, tck=0, done=0, rd_vec=0.
  - TLR sequence restarts; the model TAP reaches Test-Logic-Reset with no memory write.
